hd_beat_sequencer: RTL and testbench

Beat (W-phase) sequencer and interrupt-request conditioner for the HD-CPU hardwired controller. Generates the one-hot beat vector W[3:1] that the controller decodes, stretching or shortening each instruction's beat sequence from the controller's SHORT/LONG/STOP requests. Also handles start/single-step from the front-panel QD button, and latches the raw PULSE interrupt into a clean pending flag.

---
 rtl/hd_beat_pkg.sv | 33 +++
 rtl/hd_sync_edge.sv | 38 +++
 rtl/hd_beat_sequencer.sv | 101 ++++++++++
 tb/tb_hd_beat_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_beat_pkg.sv
// Shared beat encodings, sequencer states and the beat-advance rule for the
// HD-CPU beat sequencer.
package hd_beat_pkg;

  localparam logic [2:0] BEAT_NONE = 3'b000;
  localparam logic [2:0] BEAT_W1   = 3'b001;
  localparam logic [2:0] BEAT_W2   = 3'b010;
  localparam logic [2:0] BEAT_W3   = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    HALT
  } state_t;

  // Illegal or empty beats fall back to W1 so a corrupted W self-recovers.
  function automatic logic [2:0] next_beat(
    input logic [2:0] w,
    input logic       is_short,
    input logic       is_long
  );
    logic [2:0] nb;
    nb = BEAT_W1;
    case (w)
      BEAT_W1: nb = is_short ? BEAT_W1 : BEAT_W2;
      BEAT_W2: nb = is_long  ? BEAT_W3 : BEAT_W1;
      default: nb = BEAT_W1;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/hd_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a delay flop
// that turns its synchronised rising edge into a one-cycle pulse.
module hd_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_t3,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(negedge i_t3 or negedge i_rst_n) begin
          if (!i_rst_n) r_sync[0] <= 1'b0;
          else          r_sync[0] <= i_async;
        end
      end else begin : g_chain
        always_ff @(negedge i_t3 or negedge i_rst_n) begin
          if (!i_rst_n) r_sync[gi] <= 1'b0;
          else          r_sync[gi] <= r_sync[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(negedge i_t3 or negedge i_rst_n) begin
    if (!i_rst_n) r_dly <= 1'b0;
    else          r_dly <= r_sync[SYNC_STAGES-1];
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/hd_beat_sequencer.sv
// W-phase beat sequencer with QD start/single-step control and a conditioned
// interrupt-pending flag. Everything advances on the falling edge of T3.
module hd_beat_sequencer
  import hd_beat_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             T3,
  input  logic             CLR,
  input  logic             QD,
  input  logic             DP,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             STOP,
  input  logic             PULSE,
  input  logic             EI,
  input  logic             INTA,
  output logic [3:1]       W,
  output logic             RUNNING,
  output logic             INT_PEND,
  output logic [CNT_W-1:0] INSTR_CNT
);

  state_t           r_state;
  logic [2:0]       r_w;
  logic [2:0]       r_resume;
  logic             r_running;
  logic             r_int_pend;
  logic [CNT_W-1:0] r_cnt;

  logic       w_qd_rise;
  logic       w_ps_rise;
  logic [2:0] w_next;
  logic       w_boundary;

  hd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_qd_sync (
    .i_t3    (T3),
    .i_rst_n (CLR),
    .i_async (QD),
    .o_rise  (w_qd_rise)
  );

  hd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ps_sync (
    .i_t3    (T3),
    .i_rst_n (CLR),
    .i_async (PULSE),
    .o_rise  (w_ps_rise)
  );

  assign w_next     = next_beat(r_w, SHORT, LONG);
  assign w_boundary = (w_next == BEAT_W1);

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      r_state    <= IDLE;
      r_w        <= BEAT_NONE;
      r_resume   <= BEAT_W1;
      r_running  <= 1'b0;
      r_int_pend <= 1'b0;
      r_cnt      <= '0;
    end else begin
      // A fresh request outranks a simultaneous acknowledge.
      if (w_ps_rise && EI) r_int_pend <= 1'b1;
      else if (INTA)       r_int_pend <= 1'b0;

      case (r_state)
        IDLE, HALT: begin
          if (w_qd_rise) begin
            r_w       <= r_resume;
            r_state   <= DP ? STEP : RUN;
            r_running <= 1'b1;
          end
        end
        RUN, STEP: begin
          if (w_boundary) r_cnt <= r_cnt + CNT_W'(1);
          if (STOP) begin
            r_resume  <= w_next;
            r_w       <= BEAT_NONE;
            r_state   <= HALT;
            r_running <= 1'b0;
          end else if (r_state == STEP && w_boundary) begin
            r_resume  <= BEAT_W1;
            r_w       <= BEAT_NONE;
            r_state   <= HALT;
            r_running <= 1'b0;
          end else begin
            r_w <= w_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign W         = r_w;
  assign RUNNING   = r_running;
  assign INT_PEND  = r_int_pend;
  assign INSTR_CNT = r_cnt;

endmodule

// File: tb/tb_hd_beat_sequencer.sv
// Directed and randomised checks of hd_beat_sequencer against an
// instruction-level reference model (beat index, counters, edge histories).
module tb_hd_beat_sequencer;

  localparam int SS    = 2;
  localparam int CNT_W = 8;
  localparam int CMOD  = 1 << CNT_W;

  logic             T3, CLR, QD, DP, SHORT, LONG, STOP, PULSE, EI, INTA;
  logic [3:1]       W;
  logic             RUNNING, INT_PEND;
  logic [CNT_W-1:0] INSTR_CNT;

  int vectors;
  int miscompares;

  hd_beat_sequencer #(.SYNC_STAGES(SS), .CNT_W(CNT_W)) dut (
    .T3        (T3),
    .CLR       (CLR),
    .QD        (QD),
    .DP        (DP),
    .SHORT     (SHORT),
    .LONG      (LONG),
    .STOP      (STOP),
    .PULSE     (PULSE),
    .EI        (EI),
    .INTA      (INTA),
    .W         (W),
    .RUNNING   (RUNNING),
    .INT_PEND  (INT_PEND),
    .INSTR_CNT (INSTR_CNT)
  );

  initial T3 = 1'b1;
  always #5 T3 = ~T3;

  // Reference model: beat index 0 (none) or 1..3, plus raw input histories.
  bit m_run, m_step, m_pend;
  int m_beat, m_resume, m_cnt;
  bit qd_h[0:SS+1];
  bit ps_h[0:SS+1];

  function automatic logic [2:0] beat_vec(input int b);
    if (b == 0) return 3'b000;
    return 3'(1 << (b - 1));
  endfunction

  task automatic model_reset();
    m_run = 0; m_step = 0; m_pend = 0;
    m_beat = 0; m_resume = 1; m_cnt = 0;
    for (int i = 0; i <= SS + 1; i++) begin
      qd_h[i] = 0;
      ps_h[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit qd_rise, ps_rise, boundary;
    int nb;
    if (!CLR) begin
      model_reset();
      return;
    end
    for (int i = SS + 1; i > 0; i--) begin
      qd_h[i] = qd_h[i-1];
      ps_h[i] = ps_h[i-1];
    end
    qd_h[0] = QD;
    ps_h[0] = PULSE;
    // A level seen SS edges ago that was low one edge earlier is a rise now.
    qd_rise = qd_h[SS] && !qd_h[SS+1];
    ps_rise = ps_h[SS] && !ps_h[SS+1];

    if (ps_rise && EI) m_pend = 1;
    else if (INTA)     m_pend = 0;

    if (!m_run) begin
      if (qd_rise) begin
        m_beat = m_resume;
        m_run  = 1;
        m_step = DP;
      end
    end else begin
      if (m_beat == 1)      nb = SHORT ? 1 : 2;
      else if (m_beat == 2) nb = LONG ? 3 : 1;
      else                  nb = 1;
      boundary = (nb == 1);
      if (boundary) m_cnt = (m_cnt + 1) % CMOD;
      if (STOP || (m_step && boundary)) begin
        m_resume = STOP ? nb : 1;
        m_beat   = 0;
        m_run    = 0;
      end else begin
        m_beat = nb;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("W", 32'(W), 32'(beat_vec(m_beat)));
    chk("RUNNING", 32'(RUNNING), 32'(m_run));
    chk("INT_PEND", 32'(INT_PEND), 32'(m_pend));
    chk("INSTR_CNT", 32'(INSTR_CNT), 32'(m_cnt));
  endtask

  // One T3 period: model the falling edge, compare on the rising edge.
  task automatic cyc();
    @(negedge T3);
    model_edge();
    @(posedge T3);
    chk_model();
  endtask

  task automatic quiet_inputs();
    QD = 0; DP = 0; SHORT = 0; LONG = 0; STOP = 0;
    PULSE = 0; EI = 0; INTA = 0;
  endtask

  task automatic do_reset();
    CLR = 0;
    model_reset();
    #1;
    chk("rst_W", 32'(W), 32'h0);
    chk("rst_RUNNING", 32'(RUNNING), 32'h0);
    chk("rst_INT_PEND", 32'(INT_PEND), 32'h0);
    chk("rst_INSTR_CNT", 32'(INSTR_CNT), 32'h0);
    cyc();
    cyc();
    CLR = 1;
  endtask

  task automatic press_qd();
    QD = 1;
    cyc();
    cyc();
    QD = 0;
    cyc();
  endtask

  task automatic run_to_count(input int target);
    int guard;
    guard = 0;
    while (m_cnt != target && guard < 600) begin
      cyc();
      guard++;
    end
    if (guard >= 600) chk("timeout_count", 32'(m_cnt), 32'(target));
  endtask

  initial begin
    int guard;
    vectors     = 0;
    miscompares = 0;
    quiet_inputs();
    CLR = 0;
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) cyc();

    // Plain run: W1/W2 alternation, counter on every W2->W1.
    press_qd();
    chk("start_W", 32'(W), 32'h1);
    cyc();
    chk("run_W2", 32'(W), 32'h2);
    cyc();
    chk("run_back_W1", 32'(W), 32'h1);
    chk("run_cnt1", 32'(INSTR_CNT), 32'h1);
    for (int i = 0; i < 10; i++) cyc();

    // Alternate long and short instructions.
    for (int i = 0; i < 24; i++) begin
      SHORT = (m_cnt % 2 == 1) && (m_beat == 1);
      LONG  = (m_cnt % 2 == 0) && (m_beat == 2);
      cyc();
    end

    // STOP in a long W2: halt, then resume at W3 followed by W1.
    guard = 0;
    SHORT = 0;
    LONG  = 0;
    while (m_beat != 2 && guard < 10) begin
      cyc();
      guard++;
    end
    chk("reach_W2", 32'(W), 32'h2);
    LONG = 1;
    STOP = 1;
    cyc();
    LONG = 0;
    STOP = 0;
    chk("stop_W", 32'(W), 32'h0);
    chk("stop_RUNNING", 32'(RUNNING), 32'h0);
    cyc();
    press_qd();
    chk("resume_W3", 32'(W), 32'h4);
    cyc();
    chk("resume_W1", 32'(W), 32'h1);

    // Single-step: three presses give three instructions.
    do_reset();
    DP = 1;
    for (int p = 0; p < 3; p++) begin
      press_qd();
      for (int i = 0; i < 6; i++) cyc();
      chk("step_halt_W", 32'(W), 32'h0);
    end
    chk("step_cnt", 32'(INSTR_CNT), 32'h3);
    DP = 0;

    // Interrupt conditioning.
    do_reset();
    PULSE = 1;
    for (int i = 0; i < 4; i++) cyc();
    PULSE = 0;
    for (int i = 0; i < 3; i++) cyc();
    chk("ei0_drop", 32'(INT_PEND), 32'h0);
    EI = 1;
    PULSE = 1;
    cyc();
    cyc();
    chk("ps_not_yet", 32'(INT_PEND), 32'h0);
    cyc();
    chk("ps_set", 32'(INT_PEND), 32'h1);
    PULSE = 0;
    for (int i = 0; i < 3; i++) cyc();
    PULSE = 1;
    cyc();
    cyc();
    INTA = 1;
    cyc();
    INTA = 0;
    chk("ps_beats_inta", 32'(INT_PEND), 32'h1);
    cyc();
    INTA = 1;
    cyc();
    INTA = 0;
    chk("lone_inta", 32'(INT_PEND), 32'h0);

    // Asynchronous clear mid-W3 with a pending interrupt and a full counter.
    do_reset();
    EI = 1;
    PULSE = 1;
    for (int i = 0; i < 3; i++) cyc();
    PULSE = 0;
    SHORT = 1;
    press_qd();
    run_to_count(CMOD - 1);
    SHORT = 0;
    LONG  = 1;
    guard = 0;
    while (m_beat != 3 && guard < 10) begin
      cyc();
      guard++;
    end
    LONG = 0;
    chk("pre_clr_W3", 32'(W), 32'h4);
    chk("pre_clr_cnt", 32'(INSTR_CNT), 32'(CMOD - 1));
    chk("pre_clr_pend", 32'(INT_PEND), 32'h1);
    #2;
    quiet_inputs();
    do_reset();

    // Counter wrap from all-ones to zero.
    SHORT = 1;
    press_qd();
    run_to_count(CMOD - 1);
    cyc();
    chk("cnt_wrap", 32'(INSTR_CNT), 32'h0);
    chk("wrap_running", 32'(RUNNING), 32'h1);

    // Randomised controller and front-panel activity.
    quiet_inputs();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      QD    = ($urandom_range(0, 99) < 15);
      DP    = ($urandom_range(0, 99) < 30);
      SHORT = ($urandom_range(0, 99) < 30);
      LONG  = ($urandom_range(0, 99) < 40);
      STOP  = ($urandom_range(0, 99) < 6);
      PULSE = ($urandom_range(0, 99) < 30);
      EI    = ($urandom_range(0, 99) < 70);
      INTA  = ($urandom_range(0, 99) < 15);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
